// File: rtl/fib_pkg.sv
// Shared constants and state encoding for the Fibonacci n-th term engine.
package fib_pkg;
    localparam int FIB_W_DEF  = 8;
    localparam int FIB_NW_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fib_state_t;
endpackage

// File: rtl/fib_add_sat.sv
// W-bit adder with carry out; sums saturate to all-ones when FIBGEN_SAT_EN is defined,
// otherwise they wrap modulo 2^W.
module fib_add_sat #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum,
    output logic         o_carry
);
    logic [W:0] w_full;

    assign w_full  = {1'b0, i_a} + {1'b0, i_b};
    assign o_carry = w_full[W];

`ifdef FIBGEN_SAT_EN
    assign o_sum = w_full[W] ? {W{1'b1}} : w_full[W-1:0];
`else
    assign o_sum = w_full[W-1:0];
`endif
endmodule

// File: rtl/fib_nth_engine.sv
// Iterative F(n) engine from arbitrary seeds F(0), F(1); one term per cycle.
// Saturating sums are selected with the FIBGEN_SAT_EN macro (see fib_add_sat).
module fib_nth_engine
    import fib_pkg::*;
#(
    parameter int W  = FIB_W_DEF,
    parameter int NW = FIB_NW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [NW-1:0] n,
    input  logic [W-1:0]  seed0,
    input  logic [W-1:0]  seed1,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  result,
    output logic          overflow
);
    fib_state_t    r_state, w_state_nxt;
    logic [W-1:0]  r_prev, r_cur, r_result, w_sum;
    logic [NW-1:0] r_cnt;
    logic          r_done, r_ovf;
    logic          w_carry, w_accept, w_step, w_finish;

    fib_add_sat #(.W(W)) u_add (
        .i_a     (r_prev),
        .i_b     (r_cur),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == '0) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_step = 1'b1;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev   <= '0;
            r_cur    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_accept) begin
                r_prev <= seed0;
                r_cur  <= seed1;
                r_cnt  <= n;
                r_ovf  <= 1'b0;
            end else if (w_step) begin
                r_prev <= r_cur;
                r_cur  <= w_sum;
                r_cnt  <= r_cnt - 1'b1;
                // The last step computes F(n+1), which is never reported, so its carry is ignored.
                if (w_carry && (r_cnt != NW'(1))) r_ovf <= 1'b1;
            end
            if (w_finish) r_result <= r_prev;
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;
    assign result   = r_result;
    assign overflow = r_ovf;
endmodule
